// File: rtl/easy_debug_poll_master_pkg.sv
// ============================================================================
// Module      : easy_debug_poll_master_pkg
// Description : Shared FSM encoding and widths for the debug poll master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package easy_debug_poll_master_pkg;

    localparam int c_SAMPLE_CNT_W = 16;
    localparam int c_STALL_CNT_W  = 16;
    localparam int c_LAT_CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LAT  = 2'd2
    } poll_state_t;

endpackage

`default_nettype wire

// File: rtl/easy_debug_tick_gen.sv
// ============================================================================
// Module      : easy_debug_tick_gen
// Description : Free-running poll interval counter; one-cycle tick every
//               POLL_INTERVAL cycles while enabled, held at zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module easy_debug_tick_gen #(
    parameter int POLL_INTERVAL = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int                 c_CNT_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(POLL_INTERVAL - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_at_last;

    assign w_at_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = enable & w_at_last;

endmodule

`default_nettype wire

// File: rtl/easy_debug_poll_master.sv
// ============================================================================
// Module      : easy_debug_poll_master
// Description : Avalon-MM read initiator polling a debug slave periodically
//               or on demand; publishes latest sample, valid pulse and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module easy_debug_poll_master
    import easy_debug_poll_master_pkg::*;
#(
    parameter int ADDR_W        = 2,
    parameter int DATA_W        = 32,
    parameter int POLL_INTERVAL = 1024,
    parameter int READ_LATENCY  = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      poll_now,
    input  logic [ADDR_W-1:0]         target_addr,
    input  logic                      err_clr,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_read,
    input  logic                      avm_waitrequest,
    input  logic [DATA_W-1:0]         avm_readdata,
    output logic [DATA_W-1:0]         sample_data,
    output logic                      sample_valid,
    output logic [c_SAMPLE_CNT_W-1:0] sample_count,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam logic [c_STALL_CNT_W-1:0] c_STALL_LAST = c_STALL_CNT_W'(TIMEOUT - 1);
    localparam logic [c_LAT_CNT_W-1:0]   c_LAT_INIT   = c_LAT_CNT_W'(READ_LATENCY);

    poll_state_t               r_state;
    poll_state_t               w_next_state;
    logic                      w_tick;
    logic                      w_trigger;
    logic                      w_start;
    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_capture;
    logic                      w_enable_fall;
    logic                      r_enable_d;
    logic                      r_pending;
    logic [c_STALL_CNT_W-1:0]  r_stall_cnt;
    logic [c_LAT_CNT_W-1:0]    r_lat_cnt;
    logic [ADDR_W-1:0]         r_addr;
    logic [DATA_W-1:0]         r_sample_data;
    logic                      r_sample_valid;
    logic [c_SAMPLE_CNT_W-1:0] r_sample_count;
    logic                      r_timeout_err;

    easy_debug_tick_gen #(
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (w_tick)
    );

    assign w_trigger     = w_tick | poll_now;
    assign w_enable_fall = r_enable_d & ~enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_timeout    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger || r_pending) begin
                    w_start      = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_LAT;
                end else if (r_stall_cnt == c_STALL_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_LAT: begin
                // Counter was loaded with READ_LATENCY, so value 1 marks the capture edge.
                if (r_lat_cnt == c_LAT_CNT_W'(1)) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Bus-side counters and address latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_stall_cnt <= '0;
            r_lat_cnt   <= '0;
        end else begin
            if (w_start) begin
                r_addr      <= target_addr;
                r_stall_cnt <= '0;
            end else if ((r_state == ST_REQ) && avm_waitrequest) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (w_accept) begin
                r_lat_cnt <= c_LAT_INIT;
            end else if (r_state == ST_LAT) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
        end
    end

    // One-deep request memory; a falling enable abandons any queued poll.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable_d <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_enable_d <= enable;
            if (w_enable_fall) begin
                r_pending <= 1'b0;
            end else if (w_trigger && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_sample_count <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_sample_valid <= w_capture;
            if (w_capture) begin
                r_sample_data  <= avm_readdata;
                r_sample_count <= r_sample_count + 1'b1;
            end
            // A timeout on the same edge as err_clr keeps the error visible.
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign avm_address  = r_addr;
    assign avm_read     = (r_state == ST_REQ);
    assign busy         = (r_state != ST_IDLE);
    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign sample_count = r_sample_count;
    assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_easy_debug_poll_master.sv
// ============================================================================
// Module      : tb_easy_debug_poll_master
// Description : Directed/randomized bench with behavioural stalling slave and
//               a transaction-level scoreboard for the debug poll master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_easy_debug_poll_master;

    localparam int ADDR_W        = 2;
    localparam int DATA_W        = 32;
    localparam int POLL_INTERVAL = 8;
    localparam int READ_LATENCY  = 1;
    localparam int TIMEOUT       = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              poll_now = 1'b0;
    logic              err_clr = 1'b0;
    logic [ADDR_W-1:0] target_addr = '0;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic [15:0]       sample_count;
    logic              busy;
    logic              timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    easy_debug_poll_master #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .POLL_INTERVAL (POLL_INTERVAL),
        .READ_LATENCY  (READ_LATENCY),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .poll_now        (poll_now),
        .target_addr     (target_addr),
        .err_clr         (err_clr),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .sample_data     (sample_data),
        .sample_valid    (sample_valid),
        .sample_count    (sample_count),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave: programmable stall count per read, registered readdata.
    logic [31:0] mem [0:3];
    int          stall_cfg = 0;
    logic        stuck = 1'b0;
    int          stall_cnt = 0;

    assign avm_waitrequest = stuck | (avm_read && (stall_cnt < stall_cfg));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt    <= 0;
            avm_readdata <= '0;
        end else if (!avm_read) begin
            stall_cnt <= 0;
        end else if (avm_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt    <= 0;
            avm_readdata <= mem[avm_address];
        end
    end

    // Scoreboard: each accepted read must produce exactly one sample,
    // READ_LATENCY cycles after acceptance, carrying the addressed word.
    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t              sb[$];
    int                cyc = 0;
    int                n_cap = 0;
    int                n_starts = 0;
    logic [15:0]       count_base = '0;
    logic              prev_stalled = 1'b0;
    logic              prev_read = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            n_cap        = 0;
            prev_stalled = 1'b0;
            prev_read    = 1'b0;
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                n_cap++;
                check("valid_pulse", 32'(sample_valid), 32'd1);
                check("sample_data", sample_data, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check("no_spurious_valid", 32'(sample_valid), 32'd0);
            end
            check("sample_count", 32'(sample_count), 32'(16'(count_base + 16'(n_cap))));
            if (prev_stalled && avm_read)
                check("addr_stable", 32'(avm_address), 32'(prev_addr));
            if (avm_read && !prev_read) n_starts++;
            if (avm_read && !avm_waitrequest)
                sb.push_back('{due: cyc + 1 + READ_LATENCY, data: mem[avm_address]});
            prev_stalled = avm_read && avm_waitrequest;
            prev_read    = avm_read;
            prev_addr    = avm_address;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || sb.size() > 0) && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(n < 100), 32'd1);
    endtask

    // Counts how many cycles avm_read stays high, starting on a cycle where it is high.
    task automatic measure_read(output int hi);
        hi = 1;
        while (avm_read && hi < 40) begin
            step();
            if (avm_read) hi++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          rise[$];
        int          hi, c0, s0, idle, n;
        logic        prev;
        logic [1:0]  a;

        for (int i = 0; i < 4; i++) mem[i] = $urandom();

        // Reset state
        repeat (3) step();
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_avm_address", 32'(avm_address), 32'd0);
        check("rst_sample_data", sample_data, 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_sample_count", 32'(sample_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step();

        // Periodic polling, no stalls
        for (int i = 0; i < 4; i++) mem[i] = 32'hDEADBEEF;
        stall_cfg   = 0;
        target_addr = 2'($urandom());
        s0          = n_starts;
        enable      = 1'b1;
        prev        = 1'b0;
        for (int k = 0; k < 42; k++) begin
            step();
            if (avm_read && !prev) rise.push_back(k);
            prev = avm_read;
        end
        enable = 1'b0;
        wait_idle("t2_idle");
        check("t2_poll_count", 32'(rise.size() >= 4), 32'd1);
        for (int j = 1; j < rise.size(); j++)
            check("t2_poll_period", 32'(rise[j] - rise[j-1]), 32'(POLL_INTERVAL));
        check("t2_sample_data", sample_data, 32'hDEADBEEF);
        check("t2_sample_count", 32'(sample_count), 32'(16'(n_starts - s0)));

        // On-demand poll with 3 stall cycles; address change mid-transaction ignored
        for (int i = 0; i < 4; i++) mem[i] = $urandom();
        stall_cfg   = 3;
        a           = 2'($urandom());
        target_addr = a;
        c0          = n_cap;
        poll_now    = 1'b1;
        step();
        poll_now    = 1'b0;
        check("t3_req_latency", 32'(avm_read), 32'd1);
        check("t3_addr", 32'(avm_address), 32'(a));
        target_addr = ~a;
        measure_read(hi);
        check("t3_read_cycles", 32'(hi), 32'd4);
        wait_idle("t3_idle");
        check("t3_data", sample_data, mem[a]);
        check("t3_captures", 32'(n_cap - c0), 32'd1);

        // Stuck waitrequest -> timeout
        stuck    = 1'b1;
        c0       = n_cap;
        poll_now = 1'b1;
        step();
        poll_now = 1'b0;
        check("t4_req_latency", 32'(avm_read), 32'd1);
        measure_read(hi);
        check("t4_read_cycles", 32'(hi), 32'(TIMEOUT));
        check("t4_timeout_err", 32'(timeout_err), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        stuck = 1'b0;
        repeat (3) step();
        check("t4_no_capture", 32'(n_cap - c0), 32'd0);
        check("t4_err_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_err_clr", 32'(timeout_err), 32'd0);

        // Multiple triggers while busy -> one extra transaction
        stall_cfg   = $urandom_range(1, 2);
        target_addr = 2'($urandom());
        c0          = n_cap;
        s0          = n_starts;
        poll_now    = 1'b1;
        step();
        repeat (3) step();
        poll_now = 1'b0;
        idle = 0;
        n    = 0;
        while ((n_starts - s0) < 2 && n < 40) begin
            if (!busy) idle++;
            step();
            n++;
        end
        check("t5_idle_gap", 32'(idle), 32'd1);
        wait_idle("t5_idle");
        repeat (4) step();
        check("t5_starts", 32'(n_starts - s0), 32'd2);
        check("t5_captures", 32'(n_cap - c0), 32'd2);

        // sample_count wrap
        c0 = n_cap;
        force dut.r_sample_count = 16'hFFFF;
        count_base = 16'hFFFF - 16'(n_cap);
        step();
        release dut.r_sample_count;
        step();
        check("t6_preload", 32'(sample_count), 32'hFFFF);
        stall_cfg = 0;
        poll_now  = 1'b1;
        step();
        poll_now  = 1'b0;
        wait_idle("t6_idle");
        check("t6_wrap", 32'(sample_count), 32'd0);
        check("t6_captures", 32'(n_cap - c0), 32'd1);

        // Asynchronous reset in the middle of a stalled read
        stuck    = 1'b1;
        poll_now = 1'b1;
        step();
        poll_now = 1'b0;
        check("t1_in_req", 32'(avm_read), 32'd1);
        #2;
        reset      = 1'b1;
        count_base = '0;
        #1;
        check("t1_avm_read", 32'(avm_read), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_sample_count", 32'(sample_count), 32'd0);
        check("t1_sample_data", sample_data, 32'd0);
        check("t1_avm_address", 32'(avm_address), 32'd0);
        check("t1_timeout_err", 32'(timeout_err), 32'd0);
        stuck = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Randomized on-demand polls after reset
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) mem[i] = $urandom();
            a           = 2'($urandom());
            target_addr = a;
            stall_cfg   = $urandom_range(0, TIMEOUT - 2);
            poll_now    = 1'b1;
            step();
            poll_now    = 1'b0;
            wait_idle("rnd_idle");
            check("rnd_data", sample_data, mem[a]);
        end
        check("rnd_count", 32'(sample_count), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
